// File: rtl/line_window_buffer_pkg.sv
// Shared conv2d constants, pixel type and window-index helper for the line window buffer.
package line_window_buffer_pkg;

    localparam int unsigned DEF_WIDTH     = 8;
    localparam int unsigned DEF_KSIZE     = 3;
    localparam int unsigned DEF_MAX_DEPTH = 8;

    typedef logic [DEF_WIDTH-1:0] pixel_t;

    // Flat element index of window position (r, c); r=0 oldest row, c=0 oldest column.
    function automatic int unsigned win_idx(input int unsigned r, input int unsigned c,
                                            input int unsigned k);
        return r * k + c;
    endfunction

endpackage

// File: rtl/line_window_buffer_line_ram.sv
// One circular line store: combinational read and clocked write at the same address.
module line_ram #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_addr,
    input  logic [WIDTH-1:0]         i_wdata,
    output logic [WIDTH-1:0]         o_rdata_c
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Read returns the old word when a write hits the same address this cycle.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata_c = mem[i_addr];

endmodule

// File: rtl/line_window_buffer.sv
// Streaming KSIZE x KSIZE window generator over a raster of configurable line length.
module line_window_buffer
    import line_window_buffer_pkg::*;
#(
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned KSIZE     = DEF_KSIZE,
    parameter int unsigned MAX_DEPTH = DEF_MAX_DEPTH
) (
    input  logic                               i_clk,
    input  logic                               i_resetn,
    input  logic                               i_clear,
    input  logic [$clog2(MAX_DEPTH+1)-1:0]     i_line_len,
    input  logic                               i_wr_valid,
    input  logic [WIDTH-1:0]                   i_wr_data,
    output logic                               o_wr_ready,
    output logic                               o_rd_valid,
    output logic [WIDTH*KSIZE*KSIZE-1:0]       o_rd_window,
    input  logic                               i_rd_ready
);

    localparam int unsigned LW = $clog2(MAX_DEPTH + 1);
    localparam int unsigned CW = $clog2(MAX_DEPTH);
    localparam int unsigned RW = $clog2(KSIZE);
    localparam int unsigned NL = KSIZE - 1;

    logic [CW-1:0]    col_q, col_d;
    logic [RW-1:0]    row_q, row_d;
    logic [LW-1:0]    len_q, len_d;
    logic             valid_d;
    logic [WIDTH-1:0] win_q [KSIZE][KSIZE];
    logic [WIDTH-1:0] win_d [KSIZE][KSIZE];
    logic [WIDTH-1:0] line_rd [NL];
    logic [WIDTH-1:0] line_wd [NL];
    logic             accept;
    logic             last_col;
    logic             qualify;

    // A pixel offered alongside a clear is dropped.
    assign o_wr_ready = !o_rd_valid || i_rd_ready;
    assign accept     = i_wr_valid && o_wr_ready && !i_clear;
    assign last_col   = (LW'(col_q) == len_q - LW'(1));
    assign qualify    = (row_q == RW'(KSIZE - 1)) && (LW'(col_q) >= LW'(KSIZE - 1));

    for (genvar gi = 0; gi < NL; gi++) begin : g_line
        if (gi == 0) begin : g_first
            assign line_wd[gi] = i_wr_data;
        end else begin : g_chain
            assign line_wd[gi] = line_rd[gi-1];
        end
        line_ram #(.WIDTH(WIDTH), .DEPTH(MAX_DEPTH)) u_line_ram (
            .i_clk     (i_clk),
            .i_we      (accept),
            .i_addr    (col_q),
            .i_wdata   (line_wd[gi]),
            .o_rdata_c (line_rd[gi])
        );
    end

    // Counters, valid flag and window shift for the next cycle.
    always_comb begin
        col_d   = col_q;
        row_d   = row_q;
        len_d   = len_q;
        valid_d = o_rd_valid;
        win_d   = win_q;
        if (i_clear) begin
            col_d   = '0;
            row_d   = '0;
            valid_d = 1'b0;
            if (i_line_len < LW'(KSIZE)) begin
                len_d = LW'(KSIZE);
            end else if (i_line_len > LW'(MAX_DEPTH)) begin
                len_d = LW'(MAX_DEPTH);
            end else begin
                len_d = i_line_len;
            end
        end else begin
            if (o_rd_valid && i_rd_ready) begin
                valid_d = 1'b0;
            end
            if (accept) begin
                col_d = last_col ? '0 : col_q + CW'(1);
                if (last_col && (row_q != RW'(KSIZE - 1))) begin
                    row_d = row_q + RW'(1);
                end
                if (qualify) begin
                    valid_d = 1'b1;
                end
                for (int r = 0; r < KSIZE; r++) begin
                    for (int c = 0; c < KSIZE - 1; c++) begin
                        win_d[r][c] = win_q[r][c+1];
                    end
                end
                for (int r = 0; r < KSIZE - 1; r++) begin
                    win_d[r][KSIZE-1] = line_rd[KSIZE-2-r];
                end
                win_d[KSIZE-1][KSIZE-1] = i_wr_data;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            col_q      <= '0;
            row_q      <= '0;
            len_q      <= LW'(MAX_DEPTH);
            o_rd_valid <= 1'b0;
            for (int r = 0; r < KSIZE; r++) begin
                for (int c = 0; c < KSIZE; c++) begin
                    win_q[r][c] <= '0;
                end
            end
        end else begin
            col_q      <= col_d;
            row_q      <= row_d;
            len_q      <= len_d;
            o_rd_valid <= valid_d;
            win_q      <= win_d;
        end
    end

    always_comb begin
        o_rd_window = '0;
        for (int r = 0; r < KSIZE; r++) begin
            for (int c = 0; c < KSIZE; c++) begin
                o_rd_window[win_idx(r, c, KSIZE)*WIDTH +: WIDTH] = win_q[r][c];
            end
        end
    end

endmodule

// File: tb/tb_line_window_buffer.sv
// Self-checking bench: raster-frame reference model plus directed and random scenarios.
module tb_line_window_buffer;
    import line_window_buffer_pkg::*;

    localparam int W  = 8;
    localparam int K  = 3;
    localparam int D  = 8;
    localparam int LW = 4;
    localparam int WW = W * K * K;

    logic          i_clk;
    logic          i_resetn;
    logic          i_clear;
    logic [LW-1:0] i_line_len;
    logic          i_wr_valid;
    logic [W-1:0]  i_wr_data;
    logic          o_wr_ready;
    logic          o_rd_valid;
    logic [WW-1:0] o_rd_window;
    logic          i_rd_ready;

    int            checks   = 0;
    int            failures = 0;
    int            L        = D;
    pixel_t        frame[$];
    bit            exp_valid;
    logic [WW-1:0] exp_win;

    line_window_buffer #(.WIDTH(W), .KSIZE(K), .MAX_DEPTH(D)) dut (
        .i_clk       (i_clk),
        .i_resetn    (i_resetn),
        .i_clear     (i_clear),
        .i_line_len  (i_line_len),
        .i_wr_valid  (i_wr_valid),
        .i_wr_data   (i_wr_data),
        .o_wr_ready  (o_wr_ready),
        .o_rd_valid  (o_rd_valid),
        .o_rd_window (o_rd_window),
        .i_rd_ready  (i_rd_ready)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Window whose element (r, c) is base + r*stride + c.
    function automatic logic [WW-1:0] const_win(input int base, input int stride);
        logic [WW-1:0] w;
        w = '0;
        for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++)
                w[(r*K+c)*W +: W] = W'(base + r * stride + c);
        return w;
    endfunction

    function automatic void model_reset();
        exp_valid = 1'b0;
        exp_win   = '0;
        L         = D;
        frame.delete();
    endfunction

    // One clock: drive at negedge, advance the frame model at posedge, return at next negedge.
    task automatic step(input bit v, input logic [W-1:0] d, input bit rr,
                        input bit clr, input int len);
        bit acc;
        bit qual;
        int n, rw, cl;
        i_wr_valid = v;
        i_wr_data  = d;
        i_rd_ready = rr;
        i_clear    = clr;
        i_line_len = LW'(len);
        acc = v && (!exp_valid || rr);
        @(posedge i_clk);
        if (clr) begin
            exp_valid = 1'b0;
            L = (len < K) ? K : (len > D) ? D : len;
            frame.delete();
        end else begin
            qual = 1'b0;
            if (acc) begin
                frame.push_back(d);
                n  = frame.size() - 1;
                rw = n / L;
                cl = n % L;
                if (rw >= K - 1 && cl >= K - 1) begin
                    qual = 1'b1;
                    for (int r = 0; r < K; r++)
                        for (int c = 0; c < K; c++)
                            exp_win[(r*K+c)*W +: W] = frame[(rw-(K-1)+r)*L + (cl-(K-1)+c)];
                end
            end
            if (qual) exp_valid = 1'b1;
            else if (exp_valid && rr) exp_valid = 1'b0;
        end
        @(negedge i_clk);
        i_clear = 1'b0;
    endtask

    task automatic test_reset();
        i_resetn = 1'b0; i_clear = 1'b0; i_line_len = '0;
        i_wr_valid = 1'b0; i_wr_data = '0; i_rd_ready = 1'b1;
        model_reset();
        repeat (2) @(negedge i_clk);
        checks++;
        if (o_rd_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", o_rd_valid); end
        checks++;
        if (o_rd_window !== '0) begin failures++; $display("FAIL reset_window got=%h exp=0", o_rd_window); end
        checks++;
        if (o_wr_ready !== 1'b1) begin failures++; $display("FAIL reset_wr_ready got=%b exp=1", o_wr_ready); end
        i_resetn = 1'b1;
        @(negedge i_clk);
    endtask

    // Without any clear the line length is MAX_DEPTH.
    task automatic test_default_len();
        for (int p = 1; p <= 19; p++) begin
            step(1'b1, W'(p), 1'b1, 1'b0, 0);
            checks++;
            if (o_rd_valid !== exp_valid) begin failures++; $display("FAIL default_valid p=%0d got=%b exp=%b", p, o_rd_valid, exp_valid); end
        end
        checks++;
        if (o_rd_window !== const_win(1, 8)) begin failures++; $display("FAIL default_window got=%h exp=%h", o_rd_window, const_win(1, 8)); end
    endtask

    task automatic test_fill();
        step(1'b0, '0, 1'b1, 1'b1, 4);
        for (int p = 1; p <= 11; p++) begin
            step(1'b1, W'(p), 1'b1, 1'b0, 0);
            checks++;
            if (o_rd_valid !== (p == 11)) begin failures++; $display("FAIL fill_valid p=%0d got=%b exp=%b", p, o_rd_valid, p == 11); end
        end
        checks++;
        if (o_rd_window !== const_win(1, 4)) begin failures++; $display("FAIL fill_window got=%h exp=%h", o_rd_window, const_win(1, 4)); end
    endtask

    task automatic test_wrap();
        int cnt = 0;
        for (int p = 12; p <= 16; p++) begin
            step(1'b1, W'(p), 1'b1, 1'b0, 0);
            checks++;
            if (o_rd_valid !== exp_valid) begin failures++; $display("FAIL wrap_valid p=%0d got=%b exp=%b", p, o_rd_valid, exp_valid); end
            if (o_rd_valid) cnt++;
            if (exp_valid) begin
                checks++;
                if (o_rd_window !== exp_win) begin failures++; $display("FAIL wrap_window p=%0d got=%h exp=%h", p, o_rd_window, exp_win); end
            end
        end
        checks++;
        if (cnt !== 3) begin failures++; $display("FAIL wrap_count got=%0d exp=3", cnt); end
        checks++;
        if (o_rd_window !== const_win(6, 4)) begin failures++; $display("FAIL wrap_last got=%h exp=%h", o_rd_window, const_win(6, 4)); end
    endtask

    task automatic test_backpressure();
        step(1'b0, '0, 1'b1, 1'b1, 4);
        for (int p = 1; p <= 11; p++) step(1'b1, W'(p), 1'b1, 1'b0, 0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, W'(12), 1'b0, 1'b0, 0);
            checks++;
            if (o_wr_ready !== 1'b0) begin failures++; $display("FAIL bp_wr_ready i=%0d got=%b exp=0", i, o_wr_ready); end
            checks++;
            if (o_rd_valid !== 1'b1 || o_rd_window !== const_win(1, 4)) begin
                failures++; $display("FAIL bp_hold i=%0d valid=%b got=%h exp=%h", i, o_rd_valid, o_rd_window, const_win(1, 4));
            end
        end
        step(1'b1, W'(12), 1'b1, 1'b0, 0);
        checks++;
        if (o_rd_valid !== 1'b1 || o_rd_window !== const_win(2, 4)) begin
            failures++; $display("FAIL bp_resume valid=%b got=%h exp=%h", o_rd_valid, o_rd_window, const_win(2, 4));
        end
        step(1'b1, W'(13), 1'b1, 1'b0, 0);
        checks++;
        if (o_rd_valid !== 1'b0) begin failures++; $display("FAIL bp_drain got=%b exp=0", o_rd_valid); end
        step(1'b1, W'(14), 1'b1, 1'b0, 0);
        step(1'b1, W'(15), 1'b1, 1'b0, 0);
        checks++;
        if (o_rd_valid !== 1'b1 || o_rd_window !== const_win(5, 4)) begin
            failures++; $display("FAIL bp_next valid=%b got=%h exp=%h", o_rd_valid, o_rd_window, const_win(5, 4));
        end
    endtask

    task automatic test_clamp();
        step(1'b0, '0, 1'b1, 1'b1, 2);
        for (int p = 1; p <= 9; p++) begin
            step(1'b1, W'(p), 1'b1, 1'b0, 0);
            checks++;
            if (o_rd_valid !== exp_valid) begin failures++; $display("FAIL clamp_lo_valid p=%0d got=%b exp=%b", p, o_rd_valid, exp_valid); end
        end
        checks++;
        if (o_rd_valid !== 1'b1 || o_rd_window !== const_win(1, 3)) begin
            failures++; $display("FAIL clamp_lo_window valid=%b got=%h exp=%h", o_rd_valid, o_rd_window, const_win(1, 3));
        end
        step(1'b0, '0, 1'b1, 1'b1, 15);
        for (int p = 1; p <= 19; p++) begin
            step(1'b1, W'(p), 1'b1, 1'b0, 0);
            checks++;
            if (o_rd_valid !== (p == 19)) begin failures++; $display("FAIL clamp_hi_valid p=%0d got=%b exp=%b", p, o_rd_valid, p == 19); end
        end
        checks++;
        if (o_rd_window !== const_win(1, 8)) begin failures++; $display("FAIL clamp_hi_window got=%h exp=%h", o_rd_window, const_win(1, 8)); end
    endtask

    task automatic test_mid_frame();
        step(1'b0, '0, 1'b1, 1'b1, 4);
        for (int p = 1; p <= 6; p++) step(1'b1, W'(p), 1'b1, 1'b0, 0);
        step(1'b1, W'(99), 1'b1, 1'b1, 4);
        for (int p = 1; p <= 11; p++) begin
            step(1'b1, W'(p), 1'b1, 1'b0, 0);
            checks++;
            if (o_rd_valid !== (p == 11)) begin failures++; $display("FAIL mid_clear_valid p=%0d got=%b exp=%b", p, o_rd_valid, p == 11); end
        end
        checks++;
        if (o_rd_window !== const_win(1, 4)) begin failures++; $display("FAIL mid_clear_window got=%h exp=%h", o_rd_window, const_win(1, 4)); end
        step(1'b0, '0, 1'b0, 1'b1, 4);
        checks++;
        if (o_rd_valid !== 1'b0) begin failures++; $display("FAIL mid_clear_drop got=%b exp=0", o_rd_valid); end
        for (int p = 1; p <= 11; p++) step(1'b1, W'(p), 1'b0, 1'b0, 0);
        #2 i_resetn = 1'b0;
        #1;
        checks++;
        if (o_rd_valid !== 1'b0 || o_wr_ready !== 1'b1) begin
            failures++; $display("FAIL mid_reset valid=%b ready=%b exp=0/1", o_rd_valid, o_wr_ready);
        end
        model_reset();
        @(negedge i_clk);
        i_resetn = 1'b1;
        @(negedge i_clk);
        step(1'b0, '0, 1'b1, 1'b1, 4);
        for (int p = 1; p <= 11; p++) step(1'b1, W'(p), 1'b1, 1'b0, 0);
        checks++;
        if (o_rd_valid !== 1'b1 || o_rd_window !== const_win(1, 4)) begin
            failures++; $display("FAIL mid_reset_replay valid=%b got=%h exp=%h", o_rd_valid, o_rd_window, const_win(1, 4));
        end
    endtask

    task automatic test_random();
        bit v, rr, clr;
        step(1'b0, '0, 1'b1, 1'b1, int'($urandom_range(0, 15)));
        for (int i = 0; i < 600; i++) begin
            v   = ($urandom_range(0, 3) != 0);
            rr  = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 149) == 0);
            step(v, W'($urandom), rr, clr, int'($urandom_range(0, 15)));
            checks++;
            if (o_rd_valid !== exp_valid) begin failures++; $display("FAIL rand_valid i=%0d got=%b exp=%b", i, o_rd_valid, exp_valid); end
            checks++;
            if (o_wr_ready !== (!exp_valid || rr)) begin failures++; $display("FAIL rand_wr_ready i=%0d got=%b exp=%b", i, o_wr_ready, !exp_valid || rr); end
            if (exp_valid) begin
                checks++;
                if (o_rd_window !== exp_win) begin failures++; $display("FAIL rand_window i=%0d got=%h exp=%h", i, o_rd_window, exp_win); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_default_len();
        test_fill();
        test_wrap();
        test_backpressure();
        test_clamp();
        test_mid_frame();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/line_window_buffer.md
LINE_WINDOW_BUFFER -- requirements
Module: line_window_buffer

Interface
REQ-001 SHALL have parameter WIDTH, default 8: pixel bit width.
REQ-002 SHALL have parameter KSIZE, default 3: window edge size, legal range 2..7.
REQ-003 SHALL have parameter MAX_DEPTH, default 8: maximum line length in pixels, at least KSIZE.
REQ-004 SHALL have port i_clk, input, 1 bit: single clock, all logic on its rising edge.
REQ-005 SHALL have port i_resetn, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port i_clear, input, 1 bit: synchronous restart for a new frame.
REQ-007 SHALL have port i_line_len, input, clog2(MAX_DEPTH+1) bits: line length, sampled only on i_clear.
REQ-008 SHALL have ports i_wr_valid (input, 1 bit) and i_wr_data (input, WIDTH bits): input pixel stream.
REQ-009 SHALL have port o_wr_ready, output, 1 bit: input handshake ready.
REQ-010 SHALL have port o_rd_valid, output, 1 bit: window valid.
REQ-011 SHALL have port o_rd_window, output, WIDTH*KSIZE*KSIZE bits: the window, element index r*KSIZE+c, with r=0 the oldest row and c=0 the oldest column.
REQ-012 SHALL have port i_rd_ready, input, 1 bit: output handshake ready.

Function
REQ-013 SHALL accept a pixel when i_wr_valid && o_wr_ready, with o_wr_ready = !o_rd_valid || i_rd_ready (combinational).
REQ-014 SHALL keep a column counter col (0..len-1) and a row counter row that saturates at KSIZE-1; each accepted pixel increments col, and when col = len-1 it wraps col to 0 and increments row.
REQ-015 SHALL hold KSIZE-1 circular line stores addressed by col; on each accept, line[0][col] takes the pixel and line[i][col] takes the old line[i-1][col].
REQ-016 SHALL shift the KSIZE x KSIZE window register one column left on each accept; the new column is {line[KSIZE-2][col] .. line[0][col], pixel}, in rows 0..KSIZE-1.
REQ-017 SHALL set o_rd_valid on the cycle after accepting a pixel with row = KSIZE-1 and col >= KSIZE-1; latency 1 cycle, with o_rd_window registered together with it.
REQ-018 SHALL clear o_rd_valid after a handshake (o_rd_valid && i_rd_ready) unless a new qualifying pixel is accepted in the same cycle, in which case o_rd_valid stays 1 with the new window.
REQ-019 SHALL, while o_rd_valid && !i_rd_ready, hold o_rd_window and o_rd_valid stable and drive o_wr_ready to 0.
REQ-020 SHALL produce no window for accepts with col < KSIZE-1, so no window straddles a line boundary.
REQ-021 SHALL, on i_clear, zero col, row and o_rd_valid and load the line length register with i_line_len clamped to [KSIZE, MAX_DEPTH]; an input pixel accepted in that same cycle is dropped, and line store contents are not cleared.
REQ-022 SHALL leave row saturated at KSIZE-1 after the frame; a new frame requires i_clear.

Reset
REQ-023 SHALL, while i_resetn = 0, asynchronously force o_rd_valid=0, o_rd_window=0, col=0, row=0 and line length = MAX_DEPTH; o_wr_ready then reads 1.
REQ-024 SHALL leave the line store RAM uninitialised on reset; the valid gating of REQ-017 guarantees stale data is never output.
REQ-025 SHALL allow reset mid-frame: behaviour after release is identical to power-up.

Structure
REQ-026 SHALL take the pixel type and the default WIDTH/KSIZE constants from the shared conv2d package, together with the window-index helper function.
REQ-027 SHALL instantiate sub-module line_ram (one circular store, WIDTH x MAX_DEPTH, read-before-write at a single address) KSIZE-1 times.

Verification
All scenarios use WIDTH=8, KSIZE=3, MAX_DEPTH=8, i_clear with i_line_len=4 and i_rd_ready=1 unless stated.
REQ-028 SHALL cover the fill: write 1,2,3,... -> o_rd_valid first rises the cycle after pixel 11, with window {1,2,3,5,6,7,9,10,11}, and stays low for pixels 1..10.
REQ-029 SHALL cover line wrap: continue writing to pixel 16 -> exactly 2 windows per line (after pixels 11,12,15,16), with no valid after pixels 13 or 14.
REQ-030 SHALL cover backpressure: hold i_rd_ready=0 for 5 cycles after the first window -> o_wr_ready=0, window stable; release -> window consumed and the next accept resumes with no data lost.
REQ-031 SHALL cover clamping: i_clear with i_line_len=2 -> behaves as length 3, first window after pixel 9 = {1..9}; i_line_len=15 -> behaves as length 8.
REQ-032 SHALL cover mid-frame interruption: after 6 pixels, pulse i_clear (or drive i_resetn low) -> o_rd_valid=0 at once; a new sequence starting at 1 reproduces REQ-028 exactly.
